// File: rtl/mem_dma_initiator_if.sv
// Native memory bus between a word-copy initiator and its memory responder.
// Valid/ready handshake; wstrb 4'b0000 marks a read, 4'b1111 a full-word write.
interface mem_dma_initiator_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              io_mem_valid;
    logic              io_mem_instr;
    logic [STRB_W-1:0] io_mem_wstrb;
    logic [ADDR_W-1:0] io_mem_addr;
    logic [DATA_W-1:0] io_mem_wdata;
    logic [DATA_W-1:0] io_mem_rdata;
    logic              io_mem_ready;

    modport master (
        output io_mem_valid,
        output io_mem_instr,
        output io_mem_wstrb,
        output io_mem_addr,
        output io_mem_wdata,
        input  io_mem_rdata,
        input  io_mem_ready
    );

    modport slave (
        input  io_mem_valid,
        input  io_mem_instr,
        input  io_mem_wstrb,
        input  io_mem_addr,
        input  io_mem_wdata,
        output io_mem_rdata,
        output io_mem_ready
    );
endinterface

// File: rtl/mem_dma_initiator.sv
// Word-copy DMA initiator: one read then one write per word, with an idle bus
// cycle between transactions, abort at word boundaries and a ready timeout.
module mem_dma_initiator #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_start,
    input  logic                io_abort,
    input  logic [31:0]         io_cfg_src,
    input  logic [31:0]         io_cfg_dst,
    input  logic [LEN_W-1:0]    io_cfg_len,
    output logic                io_busy,
    output logic                io_done,
    output logic                io_error,
    mem_dma_initiator_if.master mem
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_GAP_RD,
        S_GAP_WR,
        S_FIN
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              abort_q, abort_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              valid_q, valid_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic to_expired;
    logic stop_req;

    // The last permitted wait cycle without ready; a disabled timeout never expires.
    assign to_expired = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TO_LAST));
    assign stop_req   = abort_q | io_abort;

    // FIN is the only way out of a job, so done always lags it by one registered cycle.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        data_d   = data_q;
        to_cnt_d = to_cnt_q;
        abort_d  = abort_q | (io_abort & busy_q);
        error_d  = error_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (io_start) begin
                    error_d = 1'b0;
                    if (io_cfg_len != '0) begin
                        src_d   = io_cfg_src & WORD_MASK;
                        dst_d   = io_cfg_dst & WORD_MASK;
                        len_d   = io_cfg_len;
                        addr_d  = io_cfg_src & WORD_MASK;
                        wstrb_d = '0;
                        state_d = S_RD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end

            S_RD: begin
                if (mem.io_mem_ready) begin
                    data_d   = mem.io_mem_rdata;
                    to_cnt_d = '0;
                    state_d  = S_GAP_WR;
                end else if (to_expired) begin
                    error_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_FIN;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            S_GAP_WR: begin
                addr_d  = dst_q;
                wstrb_d = '1;
                wdata_d = data_q;
                state_d = S_WR;
            end

            S_WR: begin
                if (mem.io_mem_ready) begin
                    src_d    = src_q + WORD_BYTES;
                    dst_d    = dst_q + WORD_BYTES;
                    len_d    = len_q - LEN_W'(1);
                    to_cnt_d = '0;
                    if ((len_q == LEN_W'(1)) || stop_req) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_GAP_RD;
                    end
                end else if (to_expired) begin
                    error_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = S_FIN;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            // A word boundary: an abort seen here stops before the next read starts.
            S_GAP_RD: begin
                if (stop_req) begin
                    state_d = S_FIN;
                end else begin
                    addr_d  = src_q;
                    wstrb_d = '0;
                    state_d = S_RD;
                end
            end

            S_FIN: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_RD) || (state_d == S_WR);
        busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d  = (state_q == S_FIN);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job context and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            to_cnt_q <= '0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            data_q   <= data_d;
            to_cnt_q <= to_cnt_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign io_busy          = busy_q;
    assign io_done          = done_q;
    assign io_error         = error_q;
    assign mem.io_mem_valid = valid_q;
    assign mem.io_mem_instr = 1'b0;
    assign mem.io_mem_wstrb = wstrb_q;
    assign mem.io_mem_addr  = addr_q;
    assign mem.io_mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_dma_initiator.sv
// Directed bench for mem_dma_initiator: a latency-programmable memory responder,
// a bus transaction log and one task per scenario with hand-computed expectations.
module tb_mem_dma_initiator;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             io_start = 1'b0;
    logic             io_abort = 1'b0;
    logic [31:0]      io_cfg_src = '0;
    logic [31:0]      io_cfg_dst = '0;
    logic [LEN_W-1:0] io_cfg_len = '0;
    logic             io_busy;
    logic             io_done;
    logic             io_error;

    mem_dma_initiator_if bus ();

    mem_dma_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_start   (io_start),
        .io_abort   (io_abort),
        .io_cfg_src (io_cfg_src),
        .io_cfg_dst (io_cfg_dst),
        .io_cfg_len (io_cfg_len),
        .io_busy    (io_busy),
        .io_done    (io_done),
        .io_error   (io_error),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic [31:0] src_mem [logic [31:0]];
    logic [31:0] dst_mem [logic [31:0]];
    txn_t        log_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    int done_cnt  = 0;
    int valid_cnt = 0;
    int stab_err  = 0;
    int gap_err   = 0;

    bit never_ready = 1'b0;
    int lat_lo = 2;
    int lat_hi = 2;
    int cur_lat = 0;
    int wcnt = 0;
    bit waiting = 1'b0;

    initial begin
        bus.io_mem_ready = 1'b0;
        bus.io_mem_rdata = '0;
    end

    // Responder: ready rises cur_lat cycles after valid, for one cycle, with read data.
    always @(negedge clk) begin
        if (!reset) begin
            bus.io_mem_ready = 1'b0;
            wcnt = 0;
            waiting = 1'b0;
        end else if (bus.io_mem_ready) begin
            bus.io_mem_ready = 1'b0;
            wcnt = 0;
            waiting = 1'b0;
        end else if (bus.io_mem_valid && !never_ready) begin
            if (!waiting) begin
                waiting = 1'b1;
                cur_lat = int'($urandom_range(lat_hi, lat_lo));
                wcnt = 0;
            end
            if (wcnt >= cur_lat) begin
                bus.io_mem_ready = 1'b1;
                bus.io_mem_rdata = src_mem.exists(bus.io_mem_addr) ? src_mem[bus.io_mem_addr] : 32'h0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            waiting = 1'b0;
        end
    end

    // Bus monitor: logs handshakes, stores writes, tracks stability and gap rules.
    logic        pv = 1'b0;
    logic        pacc = 1'b0;
    logic [31:0] pa = '0;
    logic [31:0] pd = '0;
    logic [3:0]  ps = '0;
    always @(posedge clk) begin
        if (reset) begin
            if (bus.io_mem_valid && pv && !pacc &&
                (bus.io_mem_addr !== pa || bus.io_mem_wstrb !== ps || bus.io_mem_wdata !== pd))
                stab_err++;
            if (bus.io_mem_valid && pacc) gap_err++;
            if (bus.io_mem_valid && bus.io_mem_ready) begin
                log_q.push_back({(bus.io_mem_wstrb == 4'hF), bus.io_mem_addr,
                                 (bus.io_mem_wstrb == 4'hF) ? bus.io_mem_wdata : bus.io_mem_rdata});
                if (bus.io_mem_wstrb == 4'hF) dst_mem[bus.io_mem_addr] = bus.io_mem_wdata;
            end
            pv   = bus.io_mem_valid;
            pa   = bus.io_mem_addr;
            ps   = bus.io_mem_wstrb;
            pd   = bus.io_mem_wdata;
            pacc = bus.io_mem_valid & bus.io_mem_ready;
        end else begin
            pv   = 1'b0;
            pacc = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (io_done) done_cnt++;
        if (bus.io_mem_valid) valid_cnt++;
    end

    function automatic logic [31:0] rd_dst(input logic [31:0] a);
        return dst_mem.exists(a) ? dst_mem[a] : 32'hxxxxxxxx;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input int len);
        tick();
        io_start   = 1'b1;
        io_cfg_src = src;
        io_cfg_dst = dst;
        io_cfg_len = LEN_W'(len);
        tick();
        io_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit got);
        cycles = 0;
        while (!io_done && cycles < budget) begin
            tick();
            cycles++;
        end
        got = io_done;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({io_busy, io_done, io_error} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status: got %b expected 000", {io_busy, io_done, io_error});
        end
        n_checks++;
        if ({bus.io_mem_valid, bus.io_mem_instr, bus.io_mem_wstrb} !== 6'b0) begin
            n_fail++; $display("FAIL reset_bus_ctrl: got %b expected 0", {bus.io_mem_valid, bus.io_mem_instr, bus.io_mem_wstrb});
        end
        n_checks++;
        if ({bus.io_mem_addr, bus.io_mem_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_bus_data: got %h expected 0", {bus.io_mem_addr, bus.io_mem_wdata});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_copy();
        int cyc, base_log, base_done, bad;
        bit got;
        logic [31:0] exp_addr;
        for (int i = 0; i < 4; i++) src_mem[32'h100 + 32'(4 * i)] = 32'h11111111 * 32'(i + 1);
        lat_lo = 2; lat_hi = 2;
        base_log = log_q.size();
        base_done = done_cnt;
        start_job(32'h100, 32'h200, 4);
        n_checks++;
        if (io_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", io_busy); end
        wait_done(200, cyc, got);
        n_checks++;
        if (!got || cyc != 32) begin n_fail++; $display("FAIL basic_latency: got %0d cycles (done=%b) expected 32", cyc, got); end
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_dst(32'h200 + 32'(4 * i)) !== 32'h11111111 * 32'(i + 1)) begin
                n_fail++; $display("FAIL basic_word%0d: got %h expected %h", i, rd_dst(32'h200 + 32'(4 * i)), 32'h11111111 * 32'(i + 1));
            end
        end
        n_checks++;
        if (log_q.size() - base_log != 8) begin n_fail++; $display("FAIL basic_txn_count: got %0d expected 8", log_q.size() - base_log); end
        bad = 0;
        for (int i = 0; i < 8 && base_log + i < log_q.size(); i++) begin
            exp_addr = ((i % 2) == 0) ? 32'h100 + 32'(4 * (i / 2)) : 32'h200 + 32'(4 * (i / 2));
            if (log_q[base_log + i].wr !== 1'((i % 2)) || log_q[base_log + i].addr !== exp_addr) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_txn_order: got %0d bad transactions expected 0", bad); end
        n_checks++;
        if (done_cnt - base_done != 1 || io_busy !== 1'b0 || io_error !== 1'b0) begin
            n_fail++; $display("FAIL basic_end_state: got done_pulses=%0d busy=%b error=%b expected 1/0/0", done_cnt - base_done, io_busy, io_error);
        end
    endtask

    task automatic test_zero_len();
        int base_valid;
        base_valid = valid_cnt;
        tick();
        io_start = 1'b1; io_cfg_src = 32'h40; io_cfg_dst = 32'h80; io_cfg_len = '0;
        tick();
        io_start = 1'b0;
        n_checks++;
        if ({io_done, io_busy} !== 2'b00) begin n_fail++; $display("FAIL zero_cycle1: got done/busy %b expected 00", {io_done, io_busy}); end
        tick();
        n_checks++;
        if ({io_done, io_busy} !== 2'b10) begin n_fail++; $display("FAIL zero_cycle2: got done/busy %b expected 10", {io_done, io_busy}); end
        tick();
        n_checks++;
        if ({io_done, io_busy} !== 2'b00) begin n_fail++; $display("FAIL zero_cycle3: got done/busy %b expected 00", {io_done, io_busy}); end
        tick();
        n_checks++;
        if (valid_cnt != base_valid) begin n_fail++; $display("FAIL zero_no_bus: got %0d valid cycles expected 0", valid_cnt - base_valid); end
    endtask

    task automatic test_handshake_random();
        int cyc, base_stab, base_gap, base_log, bad, writes;
        bit got;
        for (int i = 0; i < 16; i++) src_mem[32'h400 + 32'(4 * i)] = 32'hA5000000 + 32'(i);
        lat_lo = 1; lat_hi = 7;
        base_stab = stab_err; base_gap = gap_err; base_log = log_q.size();
        start_job(32'h400, 32'h800, 16);
        repeat (20) tick();
        io_start = 1'b1; io_cfg_src = 32'h404; io_cfg_dst = 32'h9000; io_cfg_len = LEN_W'(1);
        tick();
        io_start = 1'b0;
        wait_done(2000, cyc, got);
        tick();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL hs_done: got no done within %0d cycles expected done", cyc); end
        n_checks++;
        if (stab_err != base_stab) begin n_fail++; $display("FAIL hs_stability: got %0d changes while valid expected 0", stab_err - base_stab); end
        n_checks++;
        if (gap_err != base_gap) begin n_fail++; $display("FAIL hs_gap: got %0d back-to-back requests expected 0", gap_err - base_gap); end
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_dst(32'h800 + 32'(4 * i)) !== 32'hA5000000 + 32'(i)) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL hs_data: got %0d wrong words expected 0", bad); end
        writes = 0;
        for (int i = base_log; i < log_q.size(); i++) if (log_q[i].wr) writes++;
        n_checks++;
        if (writes != 16 || dst_mem.exists(32'h9000)) begin
            n_fail++; $display("FAIL hs_start_ignored: got %0d writes, dst9000=%0d expected 16, 0", writes, dst_mem.exists(32'h9000));
        end
        lat_lo = 2; lat_hi = 2;
    endtask

    task automatic test_abort();
        int cyc, n, base_log, base_done, writes;
        bit got, found;
        for (int i = 0; i < 10; i++) src_mem[32'h1000 + 32'(4 * i)] = 32'hB0000000 + 32'(i);
        lat_lo = 2; lat_hi = 2;
        base_log = log_q.size(); base_done = done_cnt;
        start_job(32'h1000, 32'h2000, 10);
        found = 1'b0; n = 0;
        while (!found && n < 200) begin
            found = bus.io_mem_valid && (bus.io_mem_wstrb == 4'h0) && (bus.io_mem_addr == 32'h1008);
            if (!found) begin tick(); n++; end
        end
        io_abort = 1'b1;
        tick();
        io_abort = 1'b0;
        wait_done(200, cyc, got);
        tick(); tick();
        n_checks++;
        if (!found || !got) begin n_fail++; $display("FAIL abort_flow: got found=%b done=%b expected 1/1", found, got); end
        writes = 0;
        for (int i = base_log; i < log_q.size(); i++) if (log_q[i].wr) writes++;
        n_checks++;
        if (writes != 3) begin n_fail++; $display("FAIL abort_writes: got %0d expected 3", writes); end
        n_checks++;
        if (rd_dst(32'h2008) !== 32'hB0000002 || dst_mem.exists(32'h200C)) begin
            n_fail++; $display("FAIL abort_dst: got w2=%h dst+12 written=%0d expected b0000002, 0", rd_dst(32'h2008), dst_mem.exists(32'h200C));
        end
        n_checks++;
        if (done_cnt - base_done != 1 || io_error !== 1'b0) begin
            n_fail++; $display("FAIL abort_status: got done_pulses=%0d error=%b expected 1/0", done_cnt - base_done, io_error);
        end
    endtask

    task automatic test_timeout();
        int cyc, base_valid, base_log;
        bit got;
        never_ready = 1'b1;
        base_valid = valid_cnt; base_log = log_q.size();
        start_job(32'h3000, 32'h3100, 2);
        wait_done(50, cyc, got);
        n_checks++;
        if (!got || cyc != 9) begin n_fail++; $display("FAIL to_done: got %0d cycles (done=%b) expected 9", cyc, got); end
        tick(); tick();
        n_checks++;
        if (valid_cnt - base_valid != 8) begin n_fail++; $display("FAIL to_valid_len: got %0d expected 8", valid_cnt - base_valid); end
        n_checks++;
        if (io_error !== 1'b1 || io_busy !== 1'b0 || log_q.size() != base_log) begin
            n_fail++; $display("FAIL to_status: got error=%b busy=%b txns=%0d expected 1/0/0", io_error, io_busy, log_q.size() - base_log);
        end
        never_ready = 1'b0;
        lat_lo = 2; lat_hi = 2;
        src_mem[32'h3000] = 32'hCAFEF00D;
        start_job(32'h3000, 32'h3100, 1);
        n_checks++;
        if (io_error !== 1'b0) begin n_fail++; $display("FAIL to_error_clear: got %b expected 0", io_error); end
        wait_done(100, cyc, got);
        tick();
        n_checks++;
        if (!got || cyc != 8 || rd_dst(32'h3100) !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL to_recover: got cycles=%0d data=%h expected 8, cafef00d", cyc, rd_dst(32'h3100));
        end
    endtask

    task automatic test_wrap();
        int cyc, base_log, k;
        bit got;
        logic [31:0] exp_rd [3];
        exp_rd[0] = 32'hFFFFFFF8; exp_rd[1] = 32'hFFFFFFFC; exp_rd[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) src_mem[exp_rd[i]] = 32'hC0DE0000 + 32'(i);
        lat_lo = 1; lat_hi = 1;
        base_log = log_q.size();
        start_job(32'hFFFFFFFB, 32'h500, 3);
        wait_done(200, cyc, got);
        tick();
        k = 0;
        for (int i = base_log; i < log_q.size(); i++) begin
            if (!log_q[i].wr) begin
                if (k < 3) begin
                    n_checks++;
                    if (log_q[i].addr !== exp_rd[k]) begin
                        n_fail++; $display("FAIL wrap_rd%0d: got %h expected %h", k, log_q[i].addr, exp_rd[k]);
                    end
                end
                k++;
            end
        end
        n_checks++;
        if (k != 3 || rd_dst(32'h508) !== 32'hC0DE0002 || io_error !== 1'b0) begin
            n_fail++; $display("FAIL wrap_result: got reads=%0d word2=%h error=%b expected 3, c0de0002, 0", k, rd_dst(32'h508), io_error);
        end
        lat_lo = 2; lat_hi = 2;
    endtask

    task automatic test_reset_mid();
        int cyc, n;
        bit got, found;
        lat_lo = 3; lat_hi = 3;
        start_job(32'h100, 32'h600, 4);
        found = 1'b0; n = 0;
        while (!found && n < 200) begin
            found = bus.io_mem_valid && (bus.io_mem_wstrb == 4'hF);
            if (!found) begin tick(); n++; end
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (!found || {io_busy, io_done, io_error, bus.io_mem_valid, bus.io_mem_wstrb} !== 8'h0 ||
            {bus.io_mem_addr, bus.io_mem_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL rst_async: got found=%b busy=%b valid=%b wstrb=%h addr=%h wdata=%h expected 1 and all 0",
                               found, io_busy, bus.io_mem_valid, bus.io_mem_wstrb, bus.io_mem_addr, bus.io_mem_wdata);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        start_job(32'h100, 32'h700, 2);
        wait_done(200, cyc, got);
        tick();
        n_checks++;
        if (!got || cyc != 20) begin n_fail++; $display("FAIL rst_rerun_latency: got %0d cycles (done=%b) expected 20", cyc, got); end
        n_checks++;
        if (rd_dst(32'h700) !== 32'h11111111 || rd_dst(32'h704) !== 32'h22222222) begin
            n_fail++; $display("FAIL rst_rerun_data: got %h %h expected 11111111 22222222", rd_dst(32'h700), rd_dst(32'h704));
        end
        lat_lo = 2; lat_hi = 2;
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_handshake_random();
        test_abort();
        test_timeout();
        test_wrap();
        test_reset_mid();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
